fnd_scan_ctrl: RTL and testbench
================================

// Module: fnd_scan_ctrl
// PURPOSE
//  Downstream display stage for the 0..9999 up/down counter. It takes the 14-bit binary count
//  and converts it to four BCD digits with a sequential double-dabble converter. It then
//  time-multiplexes the digits onto a 4-digit common-anode 7-segment display, one digit per
//  tick_1ms. Leading zeros can be blanked and decimal points set per digit.
// PARAMETERS
//  BLANK_LZ  1        1 = blank leading zero digits (ones digit never blanked); 0 = show all
//  DP_MASK   4'b0000  bit i = 1 lights the decimal point on digit i (0 = ones)
//  MAX_VAL   9999     inputs above this saturate to MAX_VAL before conversion
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst       in   1   reset, synchronous, active-low (0 = reset on next posedge clk)
//  tick_1ms  in   1   one-clk-wide scan/sample strobe
//  fndData   in   14  binary value to display
//  fndCom    out  4   digit enables, active-low, one-hot-low while scanning
//  fndFont   out  8   segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (rst=0 at posedge): fndCom=4'b1111 and fndFont=8'hFF.
//   - Digit regs = 0, scan_idx = 3, scan_en = 0.
//   - Conversion FSM returns to IDLE. Any conversion in flight is aborted; no partial result.
//  Conversion FSM: IDLE -> SHIFT -> LOAD -> IDLE.
//   - IDLE: on tick_1ms, capture sat = (fndData > MAX_VAL) ? MAX_VAL : fndData.
//     Clear the 16-bit BCD accumulator and go to SHIFT.
//   - SHIFT: 14 cycles, counted 13..0. Each cycle, every BCD nibble >= 5 gets +3, then
//     {bcd,bin} shifts left by 1.
//   - LOAD: 1 cycle. Copy BCD to digit regs d3..d0 all together (no tearing). Return to IDLE.
//   - Latency: digit regs hold the new value at posedge 16 after the tick edge.
//   - A tick_1ms outside IDLE does not restart or extend the conversion. It still advances
//     the scan.
//   - fndData may change at any time. Only the value captured in IDLE is shown.
//  Scan:
//   - On each tick_1ms: scan_idx <= (scan_idx==3) ? 0 : scan_idx+1, and scan_en <= 1.
//   - Outputs are registered and update 1 clk after the scan_idx change.
//   - fndCom = scan_en ? ~(4'b0001 << scan_idx) : 4'b1111.
//   - fndFont = {~DP_MASK[scan_idx], seg7(d[scan_idx])}, where seg7 is active-low.
//  Font, active-low {g..a}:
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
//   - Codes A..F never occur; if seen, show blank 7F.
//  Blanking (BLANK_LZ=1):
//   - Digit i>0 is blanked when it and all higher digits are 0.
//   - A blanked digit has g..a = 7F. The dp still follows DP_MASK.
//   - Value 0 shows only "0" on digit 0.
//  Width rules: shift register 30 bits {bcd[15:0], bin[13:0]}. Shift counter 4 bits.
//   - No arithmetic overflow is possible: each nibble is at most 9 after the +3/shift step.
// STRUCTURE
//  Shared header fnd_defs.vh:
//   - Segment font constants and the blank code.
//   - FSM state encodings (IDLE/SHIFT/LOAD).
//   - NUM_DIGITS=4 and BIN_W=14.
//  Sub-module bin2bcd_seq (start, bin[13:0] -> done pulse, bcd[15:0]) holds the conversion
//  FSM. The top holds scan, blanking, decode and output registers.
// TESTING
//  1 rst=0 for 3 clks, ticks running -> fndCom=1111, fndFont=FF on every cycle. After
//    release, first tick -> fndCom=1110.
//  2 fndData=1234, wait 20 clks, then 4 ticks -> (1110,99), (1101,B0), (1011,A4), (0111,F9).
//  3 BLANK_LZ=1: fndData=7 -> d0 font F8, d1..d3 FF. fndData=0 -> d0 C0, others FF.
//    fndData=1005 -> all four digits lit (F9,C0,C0,92).
//  4 fndData=14'h3FFF -> all digits 90 (9999). Then fndData=9999 -> identical output.
//  5 fndData=42, tick, then fndData=9876 at +5 clks -> digit regs =0042 at +16, no
//    intermediate value. 9876 appears only after the next tick plus 16 clks.
//  6 rst=0 at +7 clks into a conversion -> next clk fndCom=1111, fndFont=FF, digits 0.
//    After release, the first tick converts the current fndData cleanly.

Source files
------------

// File: rtl/fnd_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl_pkg
//   Shared definitions for the 4-digit 7-segment scan controller:
//   display geometry, conversion FSM state encoding, segment font constants
//   (active-low {g,f,e,d,c,b,a}) and small helper functions.
// ---------------------------------------------------------------------------
package fnd_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SHR_W      = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal digit to active-low segment pattern; non-decimal codes go dark.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // doubling, so pre-add 3 to carry into the next decade on the shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble converter, one shift per clock.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-low reset (aborts any conversion)
//     start_i  in   starts a conversion when idle; ignored while busy
//     bin_i    in   binary value, captured on an accepted start
//     done_o   out  one-clock pulse when bcd_o holds a fresh result
//     bcd_o    out  four packed BCD digits {d3,d2,d1,d0}
//   A start accepted at edge 0 produces done_o/bcd_o after edge 15.
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import fnd_scan_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [BIN_W-1:0]   bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  conv_state_e         state_q, state_d;
  logic [SHR_W-1:0]    shreg_q, shreg_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [SHR_W-1:0]    adj_s;

  // Next-state logic of the conversion FSM and its datapath
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    adj_s   = shreg_q;
    // BCD field sits above the binary field; correct every decade first
    for (int k = 0; k < NUM_DIGITS; k++) begin
      adj_s[BIN_W + 4*k +: 4] = add3(shreg_q[BIN_W + 4*k +: 4]);
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shreg_d = {{BCD_W{1'b0}}, bin_i};
          cnt_d   = 4'd13;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_d = {adj_s[SHR_W-2:0], 1'b0};
        if (cnt_q == 4'd0) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_LOAD: begin
        bcd_d   = shreg_q[SHR_W-1:BIN_W];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= {SHR_W{1'b0}};
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      bcd_q   <= {BCD_W{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
//   Converts a 14-bit count (saturated to MAX_VAL) to four BCD digits and
//   scans them onto a 4-digit common-anode 7-segment display, one digit per
//   tick_1ms, with optional leading-zero blanking and per-digit decimal points.
//   Ports:
//     clk       in   system clock
//     rst       in   synchronous active-low reset
//     tick_1ms  in   one-clock scan/sample strobe
//     fndData   in   binary value to display
//     fndCom    out  digit enables, active-low, registered
//     fndFont   out  segments {dp,g,f,e,d,c,b,a}, active-low, registered
// ---------------------------------------------------------------------------
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int         BLANK_LZ = 1,
  parameter logic [3:0] DP_MASK  = 4'b0000,
  parameter int         MAX_VAL  = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic [BIN_W-1:0] fndData,
  output logic [3:0]       fndCom,
  output logic [7:0]       fndFont
);

  localparam logic [BIN_W-1:0] MAX_SAT = BIN_W'(MAX_VAL);

  logic [BIN_W-1:0] sat_s;
  logic             done_s;
  logic [BCD_W-1:0] bcd_s;

  logic [BCD_W-1:0] digits_q, digits_d;
  logic [1:0]       scan_idx_q, scan_idx_d;
  logic             scan_en_q, scan_en_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;

  logic [3:0]       digit_s;
  logic [3:0]       blank_s;
  logic [6:0]       seg_s;

  // Clamp the input so the converter never sees more than four decades
  always_comb begin
    if (fndData > MAX_SAT) begin
      sat_s = MAX_SAT;
    end else begin
      sat_s = fndData;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (tick_1ms),
    .bin_i   (sat_s),
    .done_o  (done_s),
    .bcd_o   (bcd_s)
  );

  // Digit capture, scan pointer and display decode
  always_comb begin
    // All four digits change in the same cycle, so no torn value is shown
    if (done_s) begin
      digits_d = bcd_s;
    end else begin
      digits_d = digits_q;
    end

    // 2-bit pointer wraps 3 -> 0 naturally
    if (tick_1ms) begin
      scan_idx_d = scan_idx_q + 2'd1;
      scan_en_d  = 1'b1;
    end else begin
      scan_idx_d = scan_idx_q;
      scan_en_d  = scan_en_q;
    end

    digit_s = digits_q[{scan_idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher digit are zero;
    // the ones digit is always shown.
    blank_s[3] = (digits_q[15:12] == 4'd0);
    blank_s[2] = blank_s[3] && (digits_q[11:8] == 4'd0);
    blank_s[1] = blank_s[2] && (digits_q[7:4] == 4'd0);
    blank_s[0] = 1'b0;

    if ((BLANK_LZ != 0) && blank_s[scan_idx_q]) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg7(digit_s);
    end

    font_d = {~DP_MASK[scan_idx_q], seg_s};

    if (scan_en_q) begin
      com_d = ~(4'b0001 << scan_idx_q);
    end else begin
      com_d = 4'b1111;
    end
  end

  // Digit, scan and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      digits_q   <= {BCD_W{1'b0}};
      scan_idx_q <= 2'd3;
      scan_en_q  <= 1'b0;
      com_q      <= 4'b1111;
      font_q     <= 8'hFF;
    end else begin
      digits_q   <= digits_d;
      scan_idx_q <= scan_idx_d;
      scan_en_q  <= scan_en_d;
      com_q      <= com_d;
      font_q     <= font_d;
    end
  end

  assign fndCom  = com_q;
  assign fndFont = font_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1ms;
  logic [13:0] fndData;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(
    .BLANK_LZ (1),
    .DP_MASK  (4'b0000),
    .MAX_VAL  (9999)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1ms (tick_1ms),
    .fndData  (fndData),
    .fndCom   (fndCom),
    .fndFont  (fndFont)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] com, input logic [7:0] font);
    chk({tag, "_com"}, {12'd0, fndCom}, {12'd0, com});
    chk({tag, "_font"}, {8'd0, fndFont}, {8'd0, font});
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1ms = 1'b1;
    clk_n(1);
    tick_1ms = 1'b0;
  endtask

  // Load a value and keep the scan pointer where it was (four ticks)
  task automatic settle(input logic [13:0] v);
    fndData = v;
    repeat (4) begin
      pulse_tick();
      clk_n(18);
    end
  endtask

  // Starting from digit 3, scan digits 0..3 and check each one
  task automatic scan4(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
    pulse_tick(); clk_n(1); chk_out({tag, "_d0"}, 4'b1110, f0);
    pulse_tick(); clk_n(1); chk_out({tag, "_d1"}, 4'b1101, f1);
    pulse_tick(); clk_n(1); chk_out({tag, "_d2"}, 4'b1011, f2);
    pulse_tick(); clk_n(1); chk_out({tag, "_d3"}, 4'b0111, f3);
    clk_n(20);
  endtask

  initial begin
    rst      = 1'b0;
    tick_1ms = 1'b0;
    fndData  = 14'd0;

    // 1: reset held with ticks toggling
    for (int i = 0; i < 3; i++) begin
      tick_1ms = ~tick_1ms;
      clk_n(1);
      chk_out("rst_hold", 4'b1111, 8'hFF);
    end
    rst      = 1'b1;
    tick_1ms = 1'b0;
    pulse_tick();
    clk_n(1);
    chk_out("first_tick", 4'b1110, 8'hC0);
    clk_n(20);
    repeat (3) begin
      pulse_tick();
      clk_n(18);
    end

    // 2: 1234
    settle(14'd1234);
    scan4("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // 3: leading-zero blanking
    settle(14'd7);
    scan4("v7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    settle(14'd0);
    scan4("v0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    settle(14'd1005);
    scan4("v1005", 8'h92, 8'hC0, 8'hC0, 8'hF9);

    // 4: saturation
    settle(14'h3FFF);
    scan4("vsat", 8'h90, 8'h90, 8'h90, 8'h90);
    settle(14'd9999);
    scan4("v9999", 8'h90, 8'h90, 8'h90, 8'h90);

    // 5: input change during conversion
    fndData = 14'd42;
    pulse_tick();
    clk_n(4);
    fndData = 14'd9876;
    clk_n(11);
    chk("no_early_load", dut.digits_q, 16'h9999);
    clk_n(1);
    chk("load_42", dut.digits_q, 16'h0042);
    clk_n(1);
    chk_out("show_42_d0", 4'b1110, 8'hA4);
    clk_n(13);
    chk("hold_42", dut.digits_q, 16'h0042);
    pulse_tick();
    clk_n(15);
    chk("no_early_9876", dut.digits_q, 16'h0042);
    clk_n(1);
    chk("load_9876", dut.digits_q, 16'h9876);
    clk_n(1);
    chk_out("show_9876_d1", 4'b1101, 8'hF8);

    // 6: reset in the middle of a conversion
    fndData = 14'd321;
    pulse_tick();
    clk_n(6);
    rst = 1'b0;
    clk_n(1);
    chk_out("mid_rst", 4'b1111, 8'hFF);
    chk("mid_rst_digits", dut.digits_q, 16'h0000);
    rst = 1'b1;
    clk_n(15);
    chk("abort_no_result", dut.digits_q, 16'h0000);
    pulse_tick();
    clk_n(16);
    chk("post_rst_321", dut.digits_q, 16'h0321);
    clk_n(1);
    chk_out("post_rst_d0", 4'b1110, 8'hF9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
